// File: rtl/mrv1_retire_mp_if.sv
// Retire unit bus: FU completions, per-thread iqueue view, and
// retire/RF writeback results. master = pipeline side, slave = retire unit.
interface mrv1_retire_mp_if #(
  parameter int NUM_TW_P        = 8,
  parameter int DATA_WIDTH_P    = 32,
  parameter int ITAG_WIDTH_P    = 4,
  parameter int RF_ADDR_WIDTH_P = 5,
  parameter int NUM_FU_P        = 6,
  parameter int WB_PORTS_P      = 2,
  parameter int MAX_RET_P       = 4
);
  localparam int IQ_SIZE = 2**ITAG_WIDTH_P;
  localparam int TID_W   = $clog2(NUM_TW_P);
  localparam int CNT_W   = $clog2(MAX_RET_P+1);

  logic [NUM_FU_P-1:0]                    fu_done_i;
  logic [NUM_FU_P-1:0][DATA_WIDTH_P-1:0]  fu_wb_data_i;
  logic [NUM_FU_P-1:0][ITAG_WIDTH_P-1:0]  fu_itag_i;
  logic [NUM_FU_P-1:0][TID_W-1:0]         fu_tid_i;
  logic [NUM_TW_P-1:0]                    flush_i;
  logic [NUM_TW_P-1:0][ITAG_WIDTH_P-1:0]  retire_itag_i;
  logic [NUM_TW_P-1:0][IQ_SIZE-1:0]       iq_rd_vld_i;
  logic [NUM_TW_P-1:0][IQ_SIZE-1:0]
        [RF_ADDR_WIDTH_P-1:0]             iq_rd_addr_i;

  logic                                   retire_vld_o;
  logic [TID_W-1:0]                       retire_tid_o;
  logic [CNT_W-1:0]                       retire_cnt_o;
  logic [WB_PORTS_P-1:0]                  wb_vld_o;
  logic [TID_W-1:0]                       wb_tid_o;
  logic [WB_PORTS_P-1:0]
        [RF_ADDR_WIDTH_P-1:0]             wb_rd_addr_o;
  logic [WB_PORTS_P-1:0][DATA_WIDTH_P-1:0] wb_data_o;

  modport master (
    output fu_done_i, fu_wb_data_i, fu_itag_i,
    output fu_tid_i, flush_i, retire_itag_i,
    output iq_rd_vld_i, iq_rd_addr_i,
    input  retire_vld_o, retire_tid_o, retire_cnt_o,
    input  wb_vld_o, wb_tid_o, wb_rd_addr_o, wb_data_o
  );

  modport slave (
    input  fu_done_i, fu_wb_data_i, fu_itag_i,
    input  fu_tid_i, flush_i, retire_itag_i,
    input  iq_rd_vld_i, iq_rd_addr_i,
    output retire_vld_o, retire_tid_o, retire_cnt_o,
    output wb_vld_o, wb_tid_o, wb_rd_addr_o, wb_data_o
  );
endinterface

// File: rtl/mrv1_retire_mp.sv
// Multi-thread in-order retire unit: per-thread itag-indexed result buffer,
// round-robin thread grant, up to MAX_RET_P retires and WB_PORTS_P RF writes.
// Ports: clk_i, rst_i (sync, active high), bus (slave side of
// mrv1_retire_mp_if: FU completions, flush, iqueue heads/dests in;
// retire count/thread and packed RF write ports out).
module mrv1_retire_mp #(
  parameter int NUM_TW_P        = 8,
  parameter int DATA_WIDTH_P    = 32,
  parameter int ITAG_WIDTH_P    = 4,
  parameter int RF_ADDR_WIDTH_P = 5,
  parameter int NUM_FU_P        = 6,
  parameter int WB_PORTS_P      = 2,
  parameter int MAX_RET_P       = 4
) (
  input logic              clk_i,
  input logic              rst_i,
  mrv1_retire_mp_if.slave  bus
);
  localparam int IQ    = 2**ITAG_WIDTH_P;
  localparam int TID_W = $clog2(NUM_TW_P);
  localparam int CNT_W = $clog2(MAX_RET_P+1);

  typedef logic [ITAG_WIDTH_P-1:0] itag_t;
  typedef logic [TID_W-1:0]        tid_t;
  typedef logic [CNT_W-1:0]        cnt_t;

  logic [NUM_TW_P-1:0][IQ-1:0] vld_q, vld_d;
  logic [DATA_WIDTH_P-1:0]     data_q [NUM_TW_P][IQ];
  tid_t                        rr_ptr_q, rr_ptr_d;

  logic [NUM_TW_P-1:0][IQ-1:0] wr_map;
  cnt_t [NUM_TW_P-1:0]         n_ret;
  logic [NUM_TW_P-1:0]         cand;
  logic                        gnt_vld;
  tid_t                        gnt;

  // walk temporaries
  logic  w_stop;
  cnt_t  w_cnt;
  itag_t w_idx;
  tid_t  a_tid;
  itag_t o_idx;
  logic  o_placed;
  itag_t c_idx;

  // an entry needs a write port only for a real (non-x0) destination
  always_comb begin
    wr_map = '0;
    for (int t = 0; t < NUM_TW_P; t++)
      for (int i = 0; i < IQ; i++)
        wr_map[t][i] = bus.iq_rd_vld_i[t][i] &&
                       (bus.iq_rd_addr_i[t][i] != '0);
  end

  always_comb begin
    n_ret  = '0;
    cand   = '0;
    w_stop = 1'b0;
    w_cnt  = '0;
    w_idx  = '0;
    for (int t = 0; t < NUM_TW_P; t++) begin
      w_stop = 1'b0;
      w_cnt  = '0;
      for (int k = 0; k < MAX_RET_P; k++) begin
        w_idx = bus.retire_itag_i[t] + itag_t'(k);
        if (!w_stop) begin
          if (!vld_q[t][w_idx]) begin
            w_stop = 1'b1;
          end else if (wr_map[t][w_idx] &&
                       w_cnt == cnt_t'(WB_PORTS_P)) begin
            w_stop = 1'b1;
          end else begin
            n_ret[t] = n_ret[t] + cnt_t'(1);
            if (wr_map[t][w_idx])
              w_cnt = w_cnt + cnt_t'(1);
          end
        end
      end
      cand[t] = (n_ret[t] != '0) && !bus.flush_i[t];
    end
  end

  // circular priority starting at rr_ptr_q; thread count is a power
  // of two so tid arithmetic wraps by itself
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    a_tid   = '0;
    for (int o = 0; o < NUM_TW_P; o++) begin
      a_tid = rr_ptr_q + tid_t'(o);
      if (!gnt_vld && cand[a_tid]) begin
        gnt_vld = 1'b1;
        gnt     = a_tid;
      end
    end
    if (rst_i) begin
      gnt_vld = 1'b0;
      gnt     = '0;
    end
  end

  logic [WB_PORTS_P-1:0]                       wb_vld;
  logic [WB_PORTS_P-1:0][RF_ADDR_WIDTH_P-1:0]  wb_addr;
  logic [WB_PORTS_P-1:0][DATA_WIDTH_P-1:0]     wb_data;

  // writers go to the lowest free port, keeping program order
  always_comb begin
    wb_vld   = '0;
    wb_addr  = '0;
    wb_data  = '0;
    o_idx    = '0;
    o_placed = 1'b0;
    for (int k = 0; k < MAX_RET_P; k++) begin
      o_idx    = bus.retire_itag_i[gnt] + itag_t'(k);
      o_placed = 1'b0;
      if (gnt_vld && cnt_t'(k) < n_ret[gnt] &&
          wr_map[gnt][o_idx]) begin
        for (int q = 0; q < WB_PORTS_P; q++) begin
          if (!o_placed && !wb_vld[q]) begin
            o_placed   = 1'b1;
            wb_vld[q]  = 1'b1;
            wb_addr[q] = bus.iq_rd_addr_i[gnt][o_idx];
            wb_data[q] = data_q[gnt][o_idx];
          end
        end
      end
    end
  end

  assign bus.retire_vld_o = gnt_vld;
  assign bus.retire_tid_o = gnt_vld ? gnt : '0;
  assign bus.retire_cnt_o = gnt_vld ? n_ret[gnt] : '0;
  assign bus.wb_tid_o     = gnt_vld ? gnt : '0;
  assign bus.wb_vld_o     = wb_vld;
  assign bus.wb_rd_addr_o = wb_addr;
  assign bus.wb_data_o    = wb_data;

  // retire clears, then completions set, then flush wipes the thread
  always_comb begin
    vld_d = vld_q;
    c_idx = '0;
    if (gnt_vld) begin
      for (int k = 0; k < MAX_RET_P; k++) begin
        c_idx = bus.retire_itag_i[gnt] + itag_t'(k);
        if (cnt_t'(k) < n_ret[gnt])
          vld_d[gnt][c_idx] = 1'b0;
      end
    end
    for (int j = 0; j < NUM_FU_P; j++)
      if (bus.fu_done_i[j])
        vld_d[bus.fu_tid_i[j]][bus.fu_itag_i[j]] = 1'b1;
    for (int t = 0; t < NUM_TW_P; t++)
      if (bus.flush_i[t])
        vld_d[t] = '0;
    rr_ptr_d = gnt_vld ? gnt + tid_t'(1) : rr_ptr_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      vld_q    <= vld_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // later FU index overrides on a same-entry collision
  always_ff @(posedge clk_i) begin
    for (int j = 0; j < NUM_FU_P; j++)
      if (bus.fu_done_i[j] && !bus.flush_i[bus.fu_tid_i[j]])
        data_q[bus.fu_tid_i[j]][bus.fu_itag_i[j]] <=
          bus.fu_wb_data_i[j];
  end

  logic fu_dup;
  logic fu_ovw;

  always_comb begin
    fu_dup = 1'b0;
    fu_ovw = 1'b0;
    for (int j = 0; j < NUM_FU_P; j++) begin
      if (bus.fu_done_i[j] &&
          !bus.flush_i[bus.fu_tid_i[j]] &&
          vld_q[bus.fu_tid_i[j]][bus.fu_itag_i[j]])
        fu_ovw = 1'b1;
      for (int i = j + 1; i < NUM_FU_P; i++)
        if (bus.fu_done_i[j] && bus.fu_done_i[i] &&
            bus.fu_tid_i[j] == bus.fu_tid_i[i] &&
            bus.fu_itag_i[j] == bus.fu_itag_i[i])
          fu_dup = 1'b1;
    end
  end

  a_no_dup: assert property (
    @(posedge clk_i) disable iff (rst_i) !fu_dup);
  a_no_ovw: assert property (
    @(posedge clk_i) disable iff (rst_i) !fu_ovw);
endmodule

// File: tb/tb_mrv1_retire_mp.sv
// Bench for mrv1_retire_mp: directed scenarios plus a randomized
// run checked against a queue/array model of the retire rules.
module tb_mrv1_retire_mp;
  localparam int NT = 8;
  localparam int IQ = 16;
  localparam int NF = 6;
  localparam int WB = 2;
  localparam int MR = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mrv1_retire_mp_if bus ();

  mrv1_retire_mp dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  bit          mv [NT][IQ];
  logic [31:0] md [NT][IQ];
  int          mrr;
  int          head [NT];

  bit          e_vld;
  int          e_tid;
  int          e_cnt;
  bit [WB-1:0] e_wbv;
  logic [4:0]  e_addr [WB];
  logic [31:0] e_data [WB];

  function automatic bit writes(int t, int i);
    return bus.iq_rd_vld_i[t][i] &&
           (bus.iq_rd_addr_i[t][i] != 5'd0);
  endfunction

  function automatic int ready_cnt(int t);
    int n = 0;
    int w = 0;
    for (int k = 0; k < MR; k++) begin
      int i = (head[t] + k) % IQ;
      if (!mv[t][i]) break;
      if (writes(t, i) && w == WB) break;
      w += int'(writes(t, i));
      n++;
    end
    return n;
  endfunction

  function automatic void predict();
    int p;
    e_vld = 0;
    e_tid = 0;
    e_cnt = 0;
    e_wbv = '0;
    for (int q = 0; q < WB; q++) begin
      e_addr[q] = '0;
      e_data[q] = '0;
    end
    if (rst) return;
    for (int o = 0; o < NT; o++) begin
      int t = (mrr + o) % NT;
      int n = ready_cnt(t);
      if (n > 0 && !bus.flush_i[t]) begin
        e_vld = 1;
        e_tid = t;
        e_cnt = n;
        break;
      end
    end
    if (!e_vld) return;
    p = 0;
    for (int k = 0; k < e_cnt; k++) begin
      int i = (head[e_tid] + k) % IQ;
      if (writes(e_tid, i)) begin
        e_wbv[p]  = 1'b1;
        e_addr[p] = bus.iq_rd_addr_i[e_tid][i];
        e_data[p] = md[e_tid][i];
        p++;
      end
    end
  endfunction

  task automatic set_head(int t, int h);
    head[t] = h;
    bus.retire_itag_i[t] = 4'(h);
  endtask

  task automatic complete(int j, int t, int i,
                          logic [31:0] d);
    bus.fu_done_i[j]    = 1'b1;
    bus.fu_tid_i[j]     = 3'(t);
    bus.fu_itag_i[j]    = 4'(i);
    bus.fu_wb_data_i[j] = d;
  endtask

  task automatic tick();
    predict();
    if (rst) begin
      mv  = '{default: 0};
      mrr = 0;
    end else begin
      if (e_vld)
        for (int k = 0; k < e_cnt; k++)
          mv[e_tid][(head[e_tid] + k) % IQ] = 0;
      for (int j = 0; j < NF; j++)
        if (bus.fu_done_i[j] &&
            !bus.flush_i[bus.fu_tid_i[j]]) begin
          mv[bus.fu_tid_i[j]][bus.fu_itag_i[j]] = 1;
          md[bus.fu_tid_i[j]][bus.fu_itag_i[j]] =
            bus.fu_wb_data_i[j];
        end
      for (int t = 0; t < NT; t++)
        if (bus.flush_i[t]) mv[t] = '{default: 0};
      if (e_vld) mrr = (e_tid + 1) % NT;
    end
    @(posedge clk);
    @(negedge clk);
    if (e_vld)
      set_head(e_tid, (head[e_tid] + e_cnt) % IQ);
    bus.fu_done_i = '0;
    bus.flush_i   = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 13; c++) begin
      if (c == 3) rst = 1'b0;
      #1;
      total++;
      if (bus.retire_vld_o !== 1'b0 ||
          bus.wb_vld_o !== 2'b00) begin
        bad++;
        $display("FAIL reset_idle c%0d: got vld=%b wb=%b want 0/00",
                 c, bus.retire_vld_o, bus.wb_vld_o);
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    set_head(3, 14);
    bus.iq_rd_vld_i[3] = '1;
    bus.iq_rd_addr_i[3][14] = 5'd5;
    bus.iq_rd_addr_i[3][15] = 5'd6;
    bus.iq_rd_addr_i[3][0]  = 5'd7;
    bus.iq_rd_addr_i[3][1]  = 5'd8;
    complete(0, 3, 14, 32'hA0000014);
    complete(1, 3, 15, 32'hA0000015);
    complete(2, 3, 0,  32'hA0000000);
    complete(3, 3, 1,  32'hA0000001);
    #1;
    total++;
    if (bus.retire_vld_o !== 1'b0) begin
      bad++;
      $display("FAIL wrap_same_cycle: got vld=%b want 0",
               bus.retire_vld_o);
    end
    tick();
    #1;
    total++;
    if ({bus.retire_vld_o, bus.retire_tid_o,
         bus.retire_cnt_o, bus.wb_tid_o} !==
        {1'b1, 3'd3, 3'd2, 3'd3}) begin
      bad++;
      $display("FAIL wrap_c1_ret: got %b/%0d/%0d/%0d want 1/3/2/3",
               bus.retire_vld_o, bus.retire_tid_o,
               bus.retire_cnt_o, bus.wb_tid_o);
    end
    total++;
    if ({bus.wb_vld_o, bus.wb_rd_addr_o[0],
         bus.wb_rd_addr_o[1], bus.wb_data_o[0],
         bus.wb_data_o[1]} !==
        {2'b11, 5'd5, 5'd6, 32'hA0000014,
         32'hA0000015}) begin
      bad++;
      $display("FAIL wrap_c1_wb: got %b rd%0d rd%0d %h %h want 11 rd5 rd6",
               bus.wb_vld_o, bus.wb_rd_addr_o[0],
               bus.wb_rd_addr_o[1], bus.wb_data_o[0],
               bus.wb_data_o[1]);
    end
    tick();
    #1;
    total++;
    if ({bus.retire_cnt_o, bus.wb_vld_o,
         bus.wb_rd_addr_o[0], bus.wb_rd_addr_o[1],
         bus.wb_data_o[0], bus.wb_data_o[1]} !==
        {3'd2, 2'b11, 5'd7, 5'd8, 32'hA0000000,
         32'hA0000001}) begin
      bad++;
      $display("FAIL wrap_c2: got cnt=%0d %b rd%0d rd%0d %h %h want 2 11 rd7 rd8",
               bus.retire_cnt_o, bus.wb_vld_o,
               bus.wb_rd_addr_o[0], bus.wb_rd_addr_o[1],
               bus.wb_data_o[0], bus.wb_data_o[1]);
    end
    tick();
    #1;
    total++;
    if (bus.retire_vld_o !== 1'b0) begin
      bad++;
      $display("FAIL wrap_c3_idle: got vld=%b want 0",
               bus.retire_vld_o);
    end
    tick();
  endtask

  task automatic test_x0();
    set_head(0, 0);
    bus.iq_rd_vld_i[0] = '0;
    bus.iq_rd_vld_i[0][1] = 1'b1;
    bus.iq_rd_vld_i[0][3] = 1'b1;
    for (int i = 0; i < 5; i++)
      bus.iq_rd_addr_i[0][i] = 5'd3;
    bus.iq_rd_addr_i[0][1] = 5'd0;
    bus.iq_rd_addr_i[0][3] = 5'd9;
    for (int i = 0; i < 5; i++)
      complete(i, 0, i, 32'hD0 + 32'(i));
    tick();
    #1;
    total++;
    if ({bus.retire_vld_o, bus.retire_tid_o,
         bus.retire_cnt_o, bus.wb_vld_o,
         bus.wb_rd_addr_o[0], bus.wb_data_o[0],
         bus.wb_rd_addr_o[1], bus.wb_data_o[1]} !==
        {1'b1, 3'd0, 3'd4, 2'b01, 5'd9, 32'hD3,
         5'd0, 32'h0}) begin
      bad++;
      $display("FAIL x0_c1: got cnt=%0d wb=%b rd%0d %h rd%0d %h want 4 01 rd9 d3 rd0 0",
               bus.retire_cnt_o, bus.wb_vld_o,
               bus.wb_rd_addr_o[0], bus.wb_data_o[0],
               bus.wb_rd_addr_o[1], bus.wb_data_o[1]);
    end
    tick();
    #1;
    total++;
    if ({bus.retire_vld_o, bus.retire_tid_o,
         bus.retire_cnt_o, bus.wb_vld_o} !==
        {1'b1, 3'd0, 3'd1, 2'b00}) begin
      bad++;
      $display("FAIL x0_c2: got vld=%b tid=%0d cnt=%0d wb=%b want 1 0 1 00",
               bus.retire_vld_o, bus.retire_tid_o,
               bus.retire_cnt_o, bus.wb_vld_o);
    end
    tick();
  endtask

  task automatic test_rr();
    int want [3] = '{2, 5, 1};
    set_head(1, 0);
    set_head(2, 0);
    set_head(5, 0);
    complete(0, 1, 0, 32'h10);
    tick();
    complete(0, 1, 1, 32'h11);
    complete(1, 2, 0, 32'h20);
    complete(2, 5, 0, 32'h50);
    #1;
    total++;
    if ({bus.retire_vld_o, bus.retire_tid_o} !==
        {1'b1, 3'd1}) begin
      bad++;
      $display("FAIL rr_setup: got vld=%b tid=%0d want 1 1",
               bus.retire_vld_o, bus.retire_tid_o);
    end
    tick();
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if ({bus.retire_vld_o, bus.retire_tid_o} !==
          {1'b1, 3'(want[c])}) begin
        bad++;
        $display("FAIL rr_grant%0d: got vld=%b tid=%0d want 1 %0d",
                 c, bus.retire_vld_o, bus.retire_tid_o,
                 want[c]);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    set_head(4, 0);
    bus.iq_rd_vld_i[4] = '1;
    for (int i = 0; i < IQ; i++)
      bus.iq_rd_addr_i[4][i] = 5'd4;
    complete(0, 4, 0, 32'h40);
    complete(1, 4, 1, 32'h41);
    tick();
    bus.flush_i[4] = 1'b1;
    complete(0, 4, 2, 32'h42);
    #1;
    total++;
    if (bus.retire_vld_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_c1: got vld=%b tid=%0d want 0",
               bus.retire_vld_o, bus.retire_tid_o);
    end
    tick();
    #1;
    total++;
    if (dut.vld_q[4] !== 16'h0) begin
      bad++;
      $display("FAIL flush_vldq: got %h want 0000",
               dut.vld_q[4]);
    end
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (bus.retire_vld_o !== 1'b0) begin
        bad++;
        $display("FAIL flush_after%0d: got vld=%b want 0",
                 c, bus.retire_vld_o);
      end
      tick();
    end
  endtask

  task automatic test_gap();
    set_head(6, 3);
    bus.iq_rd_vld_i[6] = '1;
    for (int i = 0; i < IQ; i++)
      bus.iq_rd_addr_i[6][i] = 5'(i + 10);
    complete(0, 6, 3, 32'h63);
    complete(1, 6, 5, 32'h65);
    tick();
    #1;
    total++;
    if ({bus.retire_vld_o, bus.retire_tid_o,
         bus.retire_cnt_o, bus.wb_vld_o,
         bus.wb_rd_addr_o[0], bus.wb_data_o[0]} !==
        {1'b1, 3'd6, 3'd1, 2'b01, 5'd13, 32'h63}) begin
      bad++;
      $display("FAIL gap_c1: got cnt=%0d wb=%b rd%0d %h want 1 01 rd13 63",
               bus.retire_cnt_o, bus.wb_vld_o,
               bus.wb_rd_addr_o[0], bus.wb_data_o[0]);
    end
    tick();
    complete(0, 6, 4, 32'h64);
    #1;
    total++;
    if (bus.retire_vld_o !== 1'b0) begin
      bad++;
      $display("FAIL gap_wait: got vld=%b cnt=%0d want 0",
               bus.retire_vld_o, bus.retire_cnt_o);
    end
    tick();
    #1;
    total++;
    if ({bus.retire_cnt_o, bus.wb_vld_o,
         bus.wb_rd_addr_o[0], bus.wb_rd_addr_o[1],
         bus.wb_data_o[0], bus.wb_data_o[1]} !==
        {3'd2, 2'b11, 5'd14, 5'd15, 32'h64,
         32'h65}) begin
      bad++;
      $display("FAIL gap_fill: got cnt=%0d %b rd%0d rd%0d %h %h want 2 11 rd14 rd15",
               bus.retire_cnt_o, bus.wb_vld_o,
               bus.wb_rd_addr_o[0], bus.wb_rd_addr_o[1],
               bus.wb_data_o[0], bus.wb_data_o[1]);
    end
    tick();
  endtask

  task automatic test_random();
    bit taken [NT][IQ];
    for (int c = 0; c < 400; c++) begin
      taken = '{default: 0};
      for (int t = 0; t < NT; t++)
        for (int i = 0; i < IQ; i++) begin
          bus.iq_rd_vld_i[t][i] = 1'($urandom_range(0, 1));
          bus.iq_rd_addr_i[t][i] =
            ($urandom_range(0, 3) == 0) ? 5'd0 :
            5'($urandom_range(1, 31));
        end
      if ($urandom_range(0, 19) == 0) begin
        int ft = $urandom_range(0, NT - 1);
        bus.flush_i[ft] = 1'b1;
      end
      for (int j = 0; j < NF; j++) begin
        int t = $urandom_range(0, NT - 1);
        int i = (head[t] + $urandom_range(0, 5)) % IQ;
        if ($urandom_range(0, 2) != 0 &&
            !mv[t][i] && !taken[t][i]) begin
          taken[t][i] = 1;
          complete(j, t, i, $urandom);
        end
      end
      #1;
      predict();
      total++;
      if ({bus.retire_vld_o, bus.retire_tid_o,
           bus.retire_cnt_o, bus.wb_tid_o} !==
          {e_vld, 3'(e_tid), 3'(e_cnt), 3'(e_tid)}) begin
        bad++;
        $display("FAIL rand%0d_ret: got %b/%0d/%0d/%0d want %b/%0d/%0d",
                 c, bus.retire_vld_o, bus.retire_tid_o,
                 bus.retire_cnt_o, bus.wb_tid_o,
                 e_vld, e_tid, e_cnt);
      end
      for (int q = 0; q < WB; q++) begin
        total++;
        if ({bus.wb_vld_o[q], bus.wb_rd_addr_o[q],
             bus.wb_data_o[q]} !==
            {e_wbv[q], e_addr[q], e_data[q]}) begin
          bad++;
          $display("FAIL rand%0d_wb%0d: got %b rd%0d %h want %b rd%0d %h",
                   c, q, bus.wb_vld_o[q],
                   bus.wb_rd_addr_o[q], bus.wb_data_o[q],
                   e_wbv[q], e_addr[q], e_data[q]);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    set_head(7, 0);
    complete(0, 7, 0, 32'h70);
    tick();
    rst = 1'b1;
    #1;
    total++;
    if (bus.retire_vld_o !== 1'b0 ||
        bus.wb_vld_o !== 2'b00) begin
      bad++;
      $display("FAIL rstmid_in: got vld=%b wb=%b want 0/00",
               bus.retire_vld_o, bus.wb_vld_o);
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++;
      if (bus.retire_vld_o !== 1'b0) begin
        bad++;
        $display("FAIL rstmid_after%0d: got vld=%b tid=%0d want 0",
                 c, bus.retire_vld_o, bus.retire_tid_o);
      end
      tick();
    end
    bus.iq_rd_vld_i[2] = '1;
    for (int i = 0; i < IQ; i++)
      bus.iq_rd_addr_i[2][i] = 5'd2;
    complete(0, 2, head[2], 32'h22);
    tick();
    #1;
    total++;
    if ({bus.retire_vld_o, bus.retire_tid_o,
         bus.retire_cnt_o, bus.wb_vld_o,
         bus.wb_data_o[0]} !==
        {1'b1, 3'd2, 3'd1, 2'b01, 32'h22}) begin
      bad++;
      $display("FAIL rstmid_recover: got %b/%0d/%0d/%b %h want 1/2/1/01 22",
               bus.retire_vld_o, bus.retire_tid_o,
               bus.retire_cnt_o, bus.wb_vld_o,
               bus.wb_data_o[0]);
    end
    tick();
  endtask

  initial begin
    rst               = 1'b1;
    bus.fu_done_i     = '0;
    bus.fu_wb_data_i  = '0;
    bus.fu_itag_i     = '0;
    bus.fu_tid_i      = '0;
    bus.flush_i       = '0;
    bus.retire_itag_i = '0;
    bus.iq_rd_vld_i   = '0;
    bus.iq_rd_addr_i  = '0;
    mv  = '{default: 0};
    mrr = 0;
    for (int t = 0; t < NT; t++) head[t] = 0;
    test_reset();
    test_wrap();
    test_x0();
    test_rr();
    test_flush();
    test_gap();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
